// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM states and
// opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // True for opcodes served by the iterative multiply/divide unit.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / divide unit: one shift-add or restoring-divide step
// per cycle for WIDTH cycles. The final step is presented combinationally on
// result together with done, so the owner can register it at that same edge.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_rem,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic             div_mode;
  logic             rem_mode;
  logic [CNT_W-1:0] cnt;

  // acc_p0: partial product (MUL) or partial remainder (DIV)
  // q_p0  : remaining multiplier bits (MUL) or dividend/quotient bits (DIV)
  // b_p0  : shifted multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] q_p0;
  logic [WIDTH-1:0] b_p0;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // One iteration step; a borrow out of trial means the divisor did not fit.
  always_comb begin
    rem_sh  = {acc_p0, q_p0[WIDTH-1]};
    trial   = rem_sh - {1'b0, b_p0};
    acc_nxt = acc_p0;
    q_nxt   = q_p0;
    b_nxt   = b_p0;
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        q_nxt   = {q_p0[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        q_nxt   = {q_p0[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = acc_p0 + (q_p0[0] ? b_p0 : '0);
      q_nxt   = {1'b0, q_p0[WIDTH-1:1]};
      b_nxt   = {b_p0[WIDTH-2:0], 1'b0};
    end
  end

  assign done   = busy && (cnt == CNT_W'(WIDTH - 1));
  assign result = (div_mode && !rem_mode) ? q_nxt : acc_nxt;

  // Iteration control: busy flag, op mode and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      div_mode <= 1'b0;
      rem_mode <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      div_mode <= is_div;
      rem_mode <= is_rem;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---- p0: working registers, loaded on start and stepped while busy
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0 <= '0;
      q_p0   <= opa;
      b_p0   <= opb;
    end else if (busy) begin
      acc_p0 <= acc_nxt;
      q_p0   <= q_nxt;
      b_p0   <= b_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU between register read and writeback. Single-cycle ops
// register their result at the accept edge; MUL/DIVU/REMU run through the
// iterative unit. Results are held until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOutput,
  output logic             Zero,
  output logic             Overflow
);

  localparam int SH_W = $clog2(WIDTH);

  state_t state;
  state_t state_nxt;

  logic                    accept;
  logic                    mc_op;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SH_W-1:0]         shamt;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic [WIDTH-1:0]        res_sc;
  logic                    ovf_sc;
  logic                    seq_done;
  logic [WIDTH-1:0]        seq_result;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mc_op    = MULDIV_EN && is_multicycle(ALUOp);
  assign a_s      = data_in1;
  assign b_s      = data_in2;
  assign shamt    = data_in2[SH_W-1:0];
  assign sum      = data_in1 + data_in2;
  assign diff     = data_in1 - data_in2;

  // Single-cycle result and overflow; anything not listed yields zero.
  always_comb begin
    res_sc = '0;
    ovf_sc = 1'b0;
    case (ALUOp)
      OP_AND:  res_sc = data_in1 & data_in2;
      OP_OR:   res_sc = data_in1 | data_in2;
      OP_ADD: begin
        res_sc = sum;
        ovf_sc = (data_in1[WIDTH-1] == data_in2[WIDTH-1]) &&
                 (sum[WIDTH-1] != data_in1[WIDTH-1]);
      end
      OP_XOR:  res_sc = data_in1 ^ data_in2;
      OP_SLL:  res_sc = data_in1 << shamt;
      OP_SRL:  res_sc = data_in1 >> shamt;
      OP_SUB: begin
        res_sc = diff;
        ovf_sc = (data_in1[WIDTH-1] != data_in2[WIDTH-1]) &&
                 (diff[WIDTH-1] != data_in1[WIDTH-1]);
      end
      OP_SLT:  res_sc = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res_sc = {{(WIDTH-1){1'b0}}, (data_in1 < data_in2)};
      OP_SRA:  res_sc = a_s >>> shamt;
      OP_NOR:  res_sc = ~(data_in1 | data_in2);
      default: ;
    endcase
  end

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && mc_op),
    .is_div (ALUOp != OP_MUL),
    .is_rem (ALUOp == OP_REMU),
    .opa    (data_in1),
    .opb    (data_in2),
    .done   (seq_done),
    .result (seq_result)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave IDLE on a multi-cycle accept, return when the unit is done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && mc_op) state_nxt = (ALUOp == OP_MUL) ? MUL : DIV;
      MUL, DIV: if (seq_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // ---- p1: output registers, held until out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALUOutput <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
    end else if (accept && !mc_op) begin
      out_valid <= 1'b1;
      ALUOutput <= res_sc;
      Zero      <= (res_sc == '0);
      Overflow  <= ovf_sc;
    end else if (seq_done && (state != IDLE)) begin
      out_valid <= 1'b1;
      ALUOutput <= seq_result;
      Zero      <= (seq_result == '0);
      Overflow  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed scenarios plus randomized traffic, all results
// compared against an arithmetic reference model through a scoreboard.
module tb_alu_mc;

  localparam int W = 32;

  typedef longint unsigned u64_t;
  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in1;
  logic [W-1:0] data_in2;
  logic [3:0]   ALUOp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUOutput;
  logic         Zero;
  logic         Overflow;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  bit   rand_rdy = 1'b0;
  bit   prev_hold = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOutput (ALUOutput),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: result, overflow and latency straight from the opcode table.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, s;
    int     sh;
    u64_t   p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    e.res = '0;
    e.ovf = 1'b0;
    e.due = 1;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  begin s = sa + sb; e.res = W'(s);
               e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3:  e.res = a ^ b;
      4'd4:  e.res = a << sh;
      4'd5:  e.res = a >> sh;
      4'd6:  begin s = sa - sb; e.res = W'(s);
               e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  e.res = (sa < sb) ? 1 : 0;
      4'd8:  e.res = (a < b) ? 1 : 0;
      4'd9:  e.res = W'(sa >>> sh);
      4'd10: begin p = u64_t'(a) * u64_t'(b); e.res = W'(p); e.due = W + 1; end
      4'd12: e.res = ~(a | b);
      4'd13: begin e.res = (b == 0) ? '1 : a / b; e.due = W + 1; end
      4'd14: begin e.res = (b == 0) ? a : a % b; e.due = W + 1; end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   busy;
    if (!rst_n) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("stale_out_valid", out_valid, 1'b0);
        end else begin
          if (!prev_hold) check("latency", edge_cnt, sb_q[0].due);
          check("result", ALUOutput, sb_q[0].res);
          check("zero", Zero, sb_q[0].res == '0);
          check("overflow", Overflow, sb_q[0].ovf);
        end
      end
      busy = (sb_q.size() > 0) && !out_valid;
      check("in_ready", in_ready, !busy && (!out_valid || out_ready));
      prev_hold = out_valid && !out_ready;
      if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (in_valid && in_ready) begin
        e = model(ALUOp, data_in1, data_in2);
        e.due = edge_cnt + e.due;
        sb_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    ALUOp    = op;
    data_in1 = a;
    data_in2 = b;
    #1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", in_ready, 1'b1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] exp_res,
                             input logic exp_ovf, input int exp_wait);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, n, exp_wait);
    check({tag, "_res"}, ALUOutput, exp_res);
    check({tag, "_ovf"}, Overflow, exp_ovf);
    check({tag, "_zero"}, Zero, exp_res == '0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUOp     = '0;
    data_in1  = '0;
    data_in2  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", ALUOutput, '0);
    check("rst_zero", Zero, 1'b0);
    check("rst_ovf", Overflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    send(4'd2, 32'h7FFF_FFFF, 32'h1);
    wait_result("add_ovf", 32'h8000_0000, 1'b1, 0);
    tick();

    send(4'd6, 32'd5, 32'd5);
    check("sub_res", ALUOutput, 32'd0);
    check("sub_zero", Zero, 1'b1);
    check("b2b_ready1", in_ready, 1'b1);
    send(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("slt_res", ALUOutput, 32'd1);
    check("b2b_ready2", in_ready, 1'b1);
    send(4'd8, 32'hFFFF_FFFF, 32'd1);
    check("sltu_res", ALUOutput, 32'd0);
    check("b2b_ready3", in_ready, 1'b1);
    tick();

    send(4'd10, 32'h0001_0003, 32'h0000_0005);
    check("mul_busy", in_ready, 1'b0);
    wait_result("mul", 32'h0005_000F, 1'b0, 32);
    tick();

    send(4'd13, 32'd100, 32'd7);
    wait_result("divu", 32'd14, 1'b0, 32);
    tick();
    send(4'd14, 32'd100, 32'd7);
    wait_result("remu", 32'd2, 1'b0, 32);
    tick();
    send(4'd13, 32'd9, 32'd0);
    wait_result("divu0", 32'hFFFF_FFFF, 1'b0, 32);
    tick();

    out_ready = 1'b0;
    send(4'd9, 32'h8000_0000, 32'h24);
    wait_result("sra", 32'hF800_0000, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sra_hold_res", ALUOutput, 32'hF800_0000);
      check("sra_hold_valid", out_valid, 1'b1);
      check("sra_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("sra_cleared", out_valid, 1'b0);

    send(4'd13, 32'd1000, 32'd3);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", ALUOutput, '0);
    check("abort_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    repeat (40) tick();
    check("abort_no_stale", out_valid, 1'b0);

    rand_rdy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      send(4'($urandom_range(0, 15)), pick(), pick());
      repeat ($urandom_range(0, 1)) tick();
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
